// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width, pointer width and the
// Gray/binary conversions used by both the read-side and write-side control.
package fifo_pkg;

  localparam int ADDRESS_SIZE = 3;
  localparam int PTR_WIDTH    = ADDRESS_SIZE + 1;

  // Conversions work on 32-bit values; callers zero-extend and truncate, so
  // one definition serves every pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_rptr_empty_if.sv
// Read-side FIFO control bundle: read request and write pointer in, read
// address, Gray read pointer, empty/occupancy status out.
interface fifo_rptr_empty_if
  import fifo_pkg::*;
#(
  parameter int address_Size = ADDRESS_SIZE
);

  logic                    r_Inc;
  logic [address_Size:0]   w_Ptr;
  logic [address_Size-1:0] r_Addr;
  logic [address_Size:0]   r_Ptr;
  logic                    r_Empty;
  logic [address_Size:0]   r_Count;
  logic                    r_AlmostEmpty;

  modport master (
    output r_Inc, w_Ptr,
    input  r_Addr, r_Ptr, r_Empty, r_Count, r_AlmostEmpty
  );

  modport slave (
    input  r_Inc, w_Ptr,
    output r_Addr, r_Ptr, r_Empty, r_Count, r_AlmostEmpty
  );

endinterface

// File: rtl/fifo_rptr_empty_sync_w2r.sv
// Two-flop synchronizer bringing the Gray write pointer into the read clock
// domain. Only one bit changes per write, so each stage samples a valid code.
module sync_w2r
  import fifo_pkg::*;
#(
  parameter int address_Size = ADDRESS_SIZE
) (
  input  logic                  r_Clk,
  input  logic                  r_Rst,
  input  logic [address_Size:0] w_Ptr,
  output logic [address_Size:0] rsync_Wptr
);

  logic [address_Size:0] stage1;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs from before the edge and form a true two-flop chain.
  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      stage1     <= '0;
      rsync_Wptr <= '0;
    end else begin
      stage1     <= w_Ptr;
      rsync_Wptr <= stage1;
    end
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-domain async FIFO control: read pointers, RAM read address, registered
// empty flag and occupancy. Optional almost-empty flag under ALMOST_EMPTY_EN.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int address_Size = ADDRESS_SIZE
`ifdef ALMOST_EMPTY_EN
  , parameter int AE_THRESH = 1
`endif
) (
  input  logic               r_Clk,
  input  logic               r_Rst,
  fifo_rptr_empty_if.slave   bus
);

  localparam int PW = address_Size + 1;

  logic [PW-1:0] rbin;
  logic [PW-1:0] rgray;
  logic          empty;
  logic [PW-1:0] count;
  logic [PW-1:0] wsync;

  logic          rinc_eff;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] count_next;

  sync_w2r #(.address_Size(address_Size)) u_sync (
    .r_Clk      (r_Clk),
    .r_Rst      (r_Rst),
    .w_Ptr      (bus.w_Ptr),
    .rsync_Wptr (wsync)
  );

  // NOTE: every signal gets a value on every path through always_comb, so
  // no latch can be inferred.
  always_comb begin
    rinc_eff   = bus.r_Inc & ~empty;
    rbin_next  = rbin + PW'(rinc_eff);
    rgray_next = PW'(bin2gray(32'(rbin_next)));
    wbin       = PW'(gray2bin(32'(wsync)));
    // Wrapping subtraction yields occupancy even across the pointer MSB toggle.
    count_next = wbin - rbin_next;
  end

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) begin
      rbin  <= '0;
      rgray <= '0;
      empty <= 1'b1;
      count <= '0;
    end else begin
      rbin  <= rbin_next;
      rgray <= rgray_next;
      empty <= (rgray_next == wsync);
      count <= count_next;
    end
  end

`ifdef ALMOST_EMPTY_EN
  logic almost_empty;

  always_ff @(posedge r_Clk or negedge r_Rst) begin
    if (!r_Rst) almost_empty <= 1'b1;
    else        almost_empty <= (count_next <= PW'(AE_THRESH));
  end

  assign bus.r_AlmostEmpty = almost_empty;
`else
  assign bus.r_AlmostEmpty = 1'b0;
`endif

  assign bus.r_Addr  = rbin[address_Size-1:0];
  assign bus.r_Ptr   = rgray;
  assign bus.r_Empty = empty;
  assign bus.r_Count = count;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty (address_Size=3) against an
// integer model of total writes and reads; honours ALMOST_EMPTY_EN.
module tb_fifo_rptr_empty;

  localparam int AS = 3;
`ifdef ALMOST_EMPTY_EN
  localparam bit AE_ON = 1'b1;
`else
  localparam bit AE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_rptr_empty_if #(.address_Size(AS)) bus ();

  fifo_rptr_empty #(
    .address_Size(AS)
`ifdef ALMOST_EMPTY_EN
    , .AE_THRESH(2)
`endif
  ) dut (
    .r_Clk (clk),
    .r_Rst (rst_n),
    .bus   (bus)
  );

  // Model: absolute write/read totals; the read side sees the write total
  // from two edges before the current one.
  int wr_total, rd_total, m_count;
  int seen_q[$];
  bit m_empty, m_ae;
  int tests, fails;

  function automatic int gray(input int b);
    int m;
    m = b % 16;
    return m ^ (m / 2);
  endfunction

  function automatic logic [12:0] expected_vec();
    return {m_empty, 4'(m_count), 3'(rd_total % 8), 4'(gray(rd_total)), m_ae};
  endfunction

  function automatic logic [12:0] actual_vec();
    return {bus.r_Empty, bus.r_Count, bus.r_Addr, bus.r_Ptr, bus.r_AlmostEmpty};
  endfunction

  task automatic set_w(input int total);
    wr_total  = total;
    bus.w_Ptr = 4'(gray(total));
  endtask

  task automatic model_reset();
    seen_q.delete();
    rd_total = 0;
    m_count  = 0;
    m_empty  = 1'b1;
    m_ae     = AE_ON;
  endtask

  task automatic tick(input bit inc);
    int wseen;
    bus.r_Inc = inc;
    @(posedge clk);
    seen_q.push_back(wr_total);
    wseen = (seen_q.size() >= 3) ? seen_q[seen_q.size()-3] : 0;
    while (seen_q.size() > 3) void'(seen_q.pop_front());
    if (inc && !m_empty) rd_total++;
    m_count = wseen - rd_total;
    m_empty = (m_count == 0);
    m_ae    = AE_ON && (m_count <= 2);
    #1;
    bus.r_Inc = 1'b0;
  endtask

  task automatic do_reset(input int w);
    bus.r_Inc = 1'b0;
    rst_n     = 1'b0;
    set_w(w);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.r_Inc = 1'b0;
    rst_n     = 1'b0;
    set_w(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (actual_vec() !== expected_vec()) begin
      fails++;
      $display("FAIL reset_hold: got %h want %h", actual_vec(), expected_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      tests++;
      if (actual_vec() !== {1'b1, 4'd0, 3'd0, 4'd0, AE_ON}) begin
        fails++;
        $display("FAIL reset_read_ignored[%0d]: got %h want %h", i, actual_vec(),
                 {1'b1, 4'd0, 3'd0, 4'd0, AE_ON});
      end
    end
  endtask

  task automatic test_sync_latency();
    set_w(1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      tests++;
      if (bus.r_Empty !== (i < 2) || actual_vec() !== expected_vec()) begin
        fails++;
        $display("FAIL sync_latency[%0d]: got %h want %h", i, actual_vec(), expected_vec());
      end
    end
    tests++;
    if (bus.r_Count !== 4'd1) begin
      fails++;
      $display("FAIL sync_count: got %0d want 1", bus.r_Count);
    end
  endtask

  task automatic test_drain();
    set_w(8);
    repeat (3) tick(1'b0);
    tests++;
    if (bus.r_Count !== 4'd8 || bus.r_Empty !== 1'b0) begin
      fails++;
      $display("FAIL drain_fill: got count %0d empty %b want 8 0", bus.r_Count, bus.r_Empty);
    end
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (bus.r_Addr !== 3'(i)) begin
        fails++;
        $display("FAIL drain_addr[%0d]: got %0d want %0d", i, bus.r_Addr, i);
      end
      tick(1'b1);
      tests++;
      if (bus.r_Count !== 4'(7 - i) || bus.r_Empty !== (i == 7) ||
          actual_vec() !== expected_vec()) begin
        fails++;
        $display("FAIL drain_step[%0d]: got %h want %h", i, actual_vec(), expected_vec());
      end
    end
    tick(1'b1);
    tests++;
    if (bus.r_Ptr !== 4'b1100 || bus.r_Addr !== 3'd0 || bus.r_Empty !== 1'b1 ||
        bus.r_Count !== 4'd0) begin
      fails++;
      $display("FAIL drain_ninth_read: got ptr %b addr %0d empty %b count %0d want 1100 0 1 0",
               bus.r_Ptr, bus.r_Addr, bus.r_Empty, bus.r_Count);
    end
  endtask

  task automatic test_wrap();
    int budget;
    budget = 80;
    while (rd_total < 16 && budget > 0) begin
      if (wr_total < 16) set_w(wr_total + 1);
      tick(1'b1);
      budget--;
      tests++;
      if (actual_vec() !== expected_vec()) begin
        fails++;
        $display("FAIL wrap_step: got %h want %h", actual_vec(), expected_vec());
      end
    end
    tests++;
    if (budget == 0) begin
      fails++;
      $display("FAIL wrap_timeout: reads %0d want 16", rd_total);
    end
    tests++;
    if (bus.r_Ptr !== 4'b0000 || bus.r_Addr !== 3'd0 || bus.r_Empty !== 1'b1) begin
      fails++;
      $display("FAIL wrap_end: got ptr %b addr %0d empty %b want 0000 0 1",
               bus.r_Ptr, bus.r_Addr, bus.r_Empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (wr_total - rd_total < 8 && $urandom_range(0, 2) != 0) set_w(wr_total + 1);
      tick(1'($urandom_range(0, 1)));
      tests++;
      if (actual_vec() !== expected_vec()) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h", i, actual_vec(), expected_vec());
      end
    end
  endtask

  task automatic test_midop_reset();
    do_reset(0);
    set_w(5);
    repeat (3) tick(1'b0);
    tests++;
    if (bus.r_Count !== 4'd5) begin
      fails++;
      $display("FAIL midop_prefill: got %0d want 5", bus.r_Count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (actual_vec() !== {1'b1, 4'd0, 3'd0, 4'd0, AE_ON}) begin
      fails++;
      $display("FAIL midop_reset_async: got %h want %h", actual_vec(),
               {1'b1, 4'd0, 3'd0, 4'd0, AE_ON});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      tests++;
      if (actual_vec() !== expected_vec()) begin
        fails++;
        $display("FAIL midop_resume[%0d]: got %h want %h", i, actual_vec(), expected_vec());
      end
    end
    tests++;
    if (bus.r_Count !== 4'd5) begin
      fails++;
      $display("FAIL midop_recount: got %0d want 5", bus.r_Count);
    end
  endtask

  task automatic test_almost_empty();
    logic want;
    do_reset(0);
    set_w(4);
    repeat (3) tick(1'b0);
    for (int i = 0; i < 5; i++) begin
      want = AE_ON && (4 - i <= 2);
      tests++;
      if (bus.r_Count !== 4'(4 - i) || bus.r_AlmostEmpty !== want) begin
        fails++;
        $display("FAIL almost_empty[%0d]: got count %0d ae %b want %0d %b",
                 i, bus.r_Count, bus.r_AlmostEmpty, 4 - i, want);
      end
      if (i < 4) tick(1'b1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_sync_latency();
    test_drain();
    test_wrap();
    test_random();
    test_midop_reset();
    test_almost_empty();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
